// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU widths, opcode encodings and arbiter FSM states
package alu_pkg;
  localparam int DATA_W = 4;
  localparam int OP_W = 3;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
  localparam logic [OP_W-1:0] OP_AND  = 3'b010;
  localparam logic [OP_W-1:0] OP_OR   = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b100;
  localparam logic [OP_W-1:0] OP_NAND = 3'b101;
  localparam logic [OP_W-1:0] OP_NOR  = 3'b110;
  localparam logic [OP_W-1:0] OP_SLT  = 3'b111;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector over NREQ valid lines
//   valid      : per-source request valid
//   last_grant : index granted most recently; search starts just after it
//   grant      : first valid index at last_grant+1, +2, ... modulo NREQ
//   any_valid  : at least one valid bit set (grant is meaningless otherwise)
module rr_pick #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [ID_W-1:0] last_grant,
  output logic [ID_W-1:0] grant,
  output logic            any_valid
);
  logic [ID_W-1:0] idx;
  // Walk the ring from the farthest candidate back to the nearest so the
  // nearest valid index after last_grant is the one left standing.
  always_comb begin
    grant = '0;
    idx = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = ID_W'((int'(last_grant) + i) % NREQ);
      if (valid[idx]) grant = idx;
    end
  end
  assign any_valid = |valid;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational 4-bit ALU among NREQ requesters
//   clk, rst                    : clock, asynchronous active-high reset
//   req_valid/req_ready         : per-requester handshake (ready one-hot or zero)
//   req_a/req_b/req_op          : packed per-requester operands and opcode
//   alu_a/alu_b/alu_op          : latched operands driven to the external ALU
//   alu_result/alu_zero         : ALU outputs, captured in EXEC
//   rsp_valid/rsp_ready         : tagged response handshake
//   rsp_data/rsp_zero/rsp_id    : registered result, zero flag, requester index
//   busy                        : FSM not in IDLE
//   ops_done                    : completed response handshakes, wraps at 256
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [DATA_W*NREQ-1:0] req_a,
  input  logic [DATA_W*NREQ-1:0] req_b,
  input  logic [OP_W*NREQ-1:0]   req_op,
  output logic [DATA_W-1:0]      alu_a,
  output logic [DATA_W-1:0]      alu_b,
  output logic [OP_W-1:0]        alu_op,
  input  logic [DATA_W-1:0]      alu_result,
  input  logic                   alu_zero,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rsp_zero,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   busy,
  output logic [7:0]             ops_done
);
  state_e state;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] grant;
  logic any_valid;
  logic [DATA_W-1:0] a_v [NREQ];
  logic [DATA_W-1:0] b_v [NREQ];
  logic [OP_W-1:0] op_v [NREQ];
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_v[g] = req_a[DATA_W*g +: DATA_W];
    assign b_v[g] = req_b[DATA_W*g +: DATA_W];
    assign op_v[g] = req_op[OP_W*g +: OP_W];
  end
  rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
    .valid(req_valid),
    .last_grant(last_grant),
    .grant(grant),
    .any_valid(any_valid)
  );
  // Ready is masked by rst so no requester sees an accept while reset is held.
  assign req_ready = (!rst && state == IDLE && any_valid) ? {{(NREQ-1){1'b0}}, 1'b1} << grant : '0;
  assign busy = state != IDLE;
  // alu_a/alu_b/alu_op are the latched operand registers themselves.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      last_grant <= ID_W'(NREQ-1);
      alu_a <= '0;
      alu_b <= '0;
      alu_op <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
      rsp_id <= '0;
      ops_done <= '0;
    end else
      case (state)
        IDLE: if (any_valid) begin
          alu_a <= a_v[grant];
          alu_b <= b_v[grant];
          alu_op <= op_v[grant];
          last_grant <= grant;
          rsp_id <= grant;
          state <= EXEC;
        end
        EXEC: begin
          rsp_data <= alu_result;
          rsp_zero <= alu_zero;
          rsp_valid <= 1'b1;
          state <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          ops_done <= ops_done + 8'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scoreboard bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;
  import alu_pkg::*;
  localparam int NREQ = 4;
  localparam int ID_W = 2;
  typedef struct {
    logic [ID_W-1:0] id;
    logic [3:0] data;
    logic zero;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_ready;
  logic [4*NREQ-1:0] req_a, req_b;
  logic [3*NREQ-1:0] req_op;
  logic [3:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_op;
  logic alu_zero;
  logic rsp_valid;
  logic rsp_ready = 1'b1;
  logic [3:0] rsp_data;
  logic rsp_zero;
  logic [ID_W-1:0] rsp_id;
  logic busy;
  logic [7:0] ops_done;
  logic [3:0] pa [NREQ];
  logic [3:0] pb [NREQ];
  logic [2:0] po [NREQ];
  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [7:0] exp_ops;
  logic [ID_W-1:0] lg_m;

  alu_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_id(rsp_id),
    .busy(busy), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  assign req_a = {pa[3], pa[2], pa[1], pa[0]};
  assign req_b = {pb[3], pb[2], pb[1], pb[0]};
  assign req_op = {po[3], po[2], po[1], po[0]};

  function automatic logic [3:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NAND: return ~(a & b);
      OP_NOR:  return ~(a | b);
      default: return {3'b000, a < b};
    endcase
  endfunction

  always_comb begin
    alu_result = alu_ref(alu_a, alu_b, alu_op);
    alu_zero = alu_result == 4'd0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic observe();
    exp_t e;
    chk("ready_onehot0", 32'($onehot0(req_ready)), 1);
    if (rsp_valid && rsp_ready) begin
      if (q.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 0);
      else begin
        e = q.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_zero", rsp_zero, e.zero);
        chk("rsp_id", rsp_id, e.id);
        exp_ops++;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    observe();
  endtask

  // Hold req_valid=mask until n grants are seen; each grant is checked against
  // a round-robin reference and its expected response is queued.
  task automatic run_ops(input logic [3:0] mask, input int n);
    int got, last_cyc;
    logic [ID_W-1:0] m, idx;
    logic found;
    logic [3:0] r;
    got = 0;
    last_cyc = 0;
    req_valid = mask;
    for (int c = 0; c < 12*n + 20 && got < n; c++) begin
      #1;
      if (req_ready != '0) begin
        m = lg_m;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
          idx = ID_W'(int'(lg_m) + k);
          if (!found && mask[idx]) begin
            m = idx;
            found = 1'b1;
          end
        end
        chk("grant_id", req_ready, 4'b0001 << m);
        if (got > 0 && rsp_ready) chk("grant_gap", cyc - last_cyc, 3);
        last_cyc = cyc;
        lg_m = m;
        r = alu_ref(pa[m], pb[m], po[m]);
        q.push_back('{id: m, data: r, zero: (r == 4'd0)});
        got++;
      end
      step();
    end
    req_valid = '0;
    if (got < n) chk("grant_timeout", got, n);
  endtask

  task automatic drain();
    for (int c = 0; c < 50 && q.size() > 0; c++) step();
    chk("drain_empty", q.size(), 0);
    step();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ops_done"}, ops_done, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_zero"}, rsp_zero, 0);
    chk({tag, "_alu_a"}, alu_a, 0);
    chk({tag, "_alu_b"}, alu_b, 0);
    chk({tag, "_alu_op"}, alu_op, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      pa[i] = '0;
      pb[i] = '0;
      po[i] = '0;
    end
    exp_ops = '0;
    lg_m = ID_W'(NREQ-1);
    repeat (2) @(negedge clk);
    req_valid = 4'b1111;
    #1;
    chk_reset_outputs("reset");
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;

    pa[0] = 4'd9; pb[0] = 4'd7; po[0] = OP_ADD;
    run_ops(4'b0001, 1);
    chk("t1_exec_valid", rsp_valid, 0);
    chk("t1_exec_busy", busy, 1);
    step();
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_data", rsp_data, 0);
    chk("t1_rsp_zero", rsp_zero, 1);
    chk("t1_rsp_id", rsp_id, 0);
    step();
    chk("t1_ops_done", ops_done, 1);
    chk("t1_idle", busy, 0);

    pa[2] = 4'd3; pb[2] = 4'd5; po[2] = OP_SUB;
    run_ops(4'b0100, 1);
    step();
    chk("t2_sub_data", rsp_data, 14);
    chk("t2_sub_zero", rsp_zero, 0);
    chk("t2_sub_id", rsp_id, 2);
    step();
    pa[2] = 4'd2; pb[2] = 4'd3; po[2] = OP_SLT;
    run_ops(4'b0100, 1);
    step();
    chk("t2_slt_data", rsp_data, 1);
    chk("t2_slt_zero", rsp_zero, 0);
    chk("t2_slt_id", rsp_id, 2);
    step();
    chk("t2_ops_done", ops_done, exp_ops);

    rst = 1'b1;
    step();
    rst = 1'b0;
    q.delete();
    exp_ops = '0;
    lg_m = ID_W'(NREQ-1);
    pa[0] = 4'd4; pb[0] = 4'd12; po[0] = OP_ADD;
    pa[1] = 4'd5; pb[1] = 4'd3;  po[1] = OP_XOR;
    pa[2] = 4'd6; pb[2] = 4'd1;  po[2] = OP_NOR;
    pa[3] = 4'd2; pb[3] = 4'd9;  po[3] = OP_SLT;
    run_ops(4'b1111, 6);
    drain();
    chk("t3_ops_done", ops_done, 6);

    rsp_ready = 1'b0;
    pa[1] = 4'd15; pb[1] = 4'd15; po[1] = OP_NAND;
    run_ops(4'b0010, 1);
    step();
    chk("t4_valid_up", rsp_valid, 1);
    req_valid[3] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_hold_valid", rsp_valid, 1);
      chk("t4_hold_data", rsp_data, 0);
      chk("t4_hold_zero", rsp_zero, 1);
      chk("t4_hold_id", rsp_id, 1);
      chk("t4_hold_ready", req_ready, 0);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    step();
    chk("t4_done_valid", rsp_valid, 0);
    chk("t4_ops_done", ops_done, 7);

    pa[3] = 4'd1; pb[3] = 4'd1; po[3] = OP_AND;
    run_ops(4'b1000, 1);
    chk("t5_in_exec", busy, 1);
    rst = 1'b1;
    req_valid = 4'b1000;
    #1;
    chk_reset_outputs("t5_rst");
    q.delete();
    exp_ops = '0;
    lg_m = ID_W'(NREQ-1);
    step();
    rst = 1'b0;
    req_valid = 4'b1010;
    #1;
    chk("t5_first_grant", req_ready, 4'b0010);
    run_ops(4'b1010, 1);
    drain();
    chk("t5_ops_done", ops_done, 1);

    pa[0] = 4'd8; pb[0] = 4'd8; po[0] = OP_SUB;
    run_ops(4'b0001, 255 - int'(exp_ops));
    drain();
    chk("t6_ops_255", ops_done, 255);
    run_ops(4'b0001, 1);
    drain();
    chk("t6_ops_wrap", ops_done, 0);
    chk("t6_ops_model", ops_done, exp_ops);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
